qbus_cycle_seq: RTL and testbench

//  Q-bus transaction sequencer downstream of the control chip. Converts its cycle requests
//  (syn/di/do/wrby/inrak) into timed BSYNC/BDIN/BDOUT/BWTBT/BIAKO strobes and DAL direction.

---
 rtl/qbus_pkg.sv | 24 ++
 rtl/qbus_sync.sv | 20 ++
 rtl/qbus_cycle_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_qbus_cycle_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared types and default timing for the Q-bus cycle sequencer.
package qbus_pkg;

  localparam int DAL_W      = 16;
  localparam int CNT_W      = 16;
  localparam int T_ASET_DEF = 2;
  localparam int T_DSET_DEF = 2;
  localparam int TMO_DEF    = 1024;
  localparam int SYNC_N_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ASET     = 4'd1,
    ST_ADDR     = 4'd2,
    ST_DIN      = 4'd3,
    ST_DIN_REL  = 4'd4,
    ST_DSET     = 4'd5,
    ST_DOUT     = 4'd6,
    ST_DOUT_REL = 4'd7,
    ST_IAK      = 4'd8,
    ST_ABORT    = 4'd9
  } state_t;

endpackage

// File: rtl/qbus_sync.sv
// N-stage synchronizer for an asynchronous single-bit input.
module qbus_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (srst) stage_reg <= '0;
    else      stage_reg <= {stage_reg[N-2:0], d};
  end

  assign q = stage_reg[N-1];

endmodule

// File: rtl/qbus_cycle_seq.sv
// Q-bus transaction sequencer: turns control-chip cycle requests into timed
// bus strobes, runs the RPLY handshake and flags bus timeouts.
module qbus_cycle_seq
  import qbus_pkg::*;
#(
  parameter int T_ASET = T_ASET_DEF,
  parameter int T_DSET = T_DSET_DEF,
  parameter int TMO    = TMO_DEF,
  parameter int SYNC_N = SYNC_N_DEF
) (
  input  logic             pin_clk,
  input  logic             pin_rst,
  input  logic             cc_syn,
  input  logic             cc_di,
  input  logic             cc_do,
  input  logic             cc_wrby,
  input  logic             cc_inrak,
  output logic             cc_ra,
  output logic             cc_berr,
  input  logic [DAL_W-1:0] ad_in,
  output logic [DAL_W-1:0] rd_data,
  input  logic [DAL_W-1:0] dal_in,
  output logic [DAL_W-1:0] dal_out,
  output logic             dal_oe,
  output logic             bsync_o,
  output logic             bdin_o,
  output logic             bdout_o,
  output logic             bwtbt_o,
  output logic             biako_o,
  input  logic             brply_in
);

  logic rply;

  qbus_sync #(.N(SYNC_N)) u_rply_sync (
    .clk  (pin_clk),
    .srst (pin_rst),
    .d    (brply_in),
    .q    (rply)
  );

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               syn_prev_reg;
  logic               iak_reg, iak_next;
  logic               bsync_reg, bsync_next;
  logic               bdin_reg, bdin_next;
  logic               bdout_reg, bdout_next;
  logic               bwtbt_reg, bwtbt_next;
  logic               biako_reg, biako_next;
  logic               dal_oe_reg, dal_oe_next;
  logic               ra_reg, ra_next;
  logic               berr_reg, berr_next;
  logic [DAL_W-1:0]   dal_out_reg, dal_out_next;
  logic [DAL_W-1:0]   rd_data_reg, rd_data_next;
  logic               timeout;

  assign timeout = (cnt_reg == CNT_W'(TMO - 1));

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      syn_prev_reg <= 1'b0;
      iak_reg      <= 1'b0;
      bsync_reg    <= 1'b0;
      bdin_reg     <= 1'b0;
      bdout_reg    <= 1'b0;
      bwtbt_reg    <= 1'b0;
      biako_reg    <= 1'b0;
      dal_oe_reg   <= 1'b0;
      ra_reg       <= 1'b0;
      berr_reg     <= 1'b0;
      dal_out_reg  <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      syn_prev_reg <= cc_syn;
      iak_reg      <= iak_next;
      bsync_reg    <= bsync_next;
      bdin_reg     <= bdin_next;
      bdout_reg    <= bdout_next;
      bwtbt_reg    <= bwtbt_next;
      biako_reg    <= biako_next;
      dal_oe_reg   <= dal_oe_next;
      ra_reg       <= ra_next;
      berr_reg     <= berr_next;
      dal_out_reg  <= dal_out_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    iak_next     = iak_reg;
    bsync_next   = bsync_reg;
    bdin_next    = bdin_reg;
    bdout_next   = bdout_reg;
    bwtbt_next   = bwtbt_reg;
    biako_next   = biako_reg;
    dal_oe_next  = dal_oe_reg;
    ra_next      = ra_reg;
    berr_next    = 1'b0;
    dal_out_next = dal_out_reg;
    rd_data_next = rd_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cc_syn && !syn_prev_reg) begin
          state_next   = ST_ASET;
          dal_out_next = ad_in;
          dal_oe_next  = 1'b1;
        end else if (cc_inrak && cc_di && !cc_syn) begin
          state_next = ST_IAK;
          bdin_next  = 1'b1;
          biako_next = 1'b1;
          iak_next   = 1'b1;
        end
      end
      // Compare against T_ASET (not T_ASET-1) so bsync lands T_ASET+1 clocks after syn.
      ST_ASET: begin
        if (cnt_reg == CNT_W'(T_ASET)) begin
          state_next  = ST_ADDR;
          bsync_next  = 1'b1;
          dal_oe_next = 1'b0;
        end
      end
      ST_ADDR: begin
        if (cc_di) begin
          state_next = ST_DIN;
          bdin_next  = 1'b1;
          iak_next   = 1'b0;
        end else if (cc_do) begin
          state_next   = ST_DSET;
          dal_out_next = ad_in;
          dal_oe_next  = 1'b1;
          bwtbt_next   = cc_wrby;
        end else if (!cc_syn) begin
          state_next = ST_IDLE;
          bsync_next = 1'b0;
        end
      end
      ST_DIN, ST_IAK: begin
        if (rply) begin
          state_next   = ST_DIN_REL;
          rd_data_next = dal_in;
          ra_next      = 1'b1;
        end else if (timeout) begin
          state_next = ST_ABORT;
          berr_next  = 1'b1;
          bdin_next  = 1'b0;
          biako_next = 1'b0;
        end
      end
      // Shared by reads and interrupt acknowledges; iak_reg picks the exit.
      ST_DIN_REL: begin
        if (!cc_di) begin
          bdin_next  = 1'b0;
          biako_next = 1'b0;
          ra_next    = 1'b0;
          if (!rply) state_next = iak_reg ? ST_IDLE : ST_ADDR;
        end
      end
      ST_DSET: begin
        if (cnt_reg == CNT_W'(T_DSET - 1)) begin
          state_next = ST_DOUT;
          bdout_next = 1'b1;
        end
      end
      ST_DOUT: begin
        if (rply) begin
          state_next = ST_DOUT_REL;
          ra_next    = 1'b1;
        end else if (timeout) begin
          state_next  = ST_ABORT;
          berr_next   = 1'b1;
          bdout_next  = 1'b0;
          bwtbt_next  = 1'b0;
          dal_oe_next = 1'b0;
        end
      end
      ST_DOUT_REL: begin
        if (!cc_do) begin
          bdout_next  = 1'b0;
          ra_next     = 1'b0;
          dal_oe_next = 1'b0;
          bwtbt_next  = 1'b0;
          if (!rply) state_next = ST_ADDR;
        end
      end
      ST_ABORT: begin
        if (!cc_di && !cc_do && !cc_syn) begin
          state_next = ST_IDLE;
          bsync_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counter restarts on every state change; timeout only accrues while waiting for RPLY.
  always_comb begin
    cnt_next = '0;
    if (state_next == state_reg) begin
      case (state_reg)
        ST_ASET, ST_DSET:        cnt_next = cnt_reg + CNT_W'(1);
        ST_DIN, ST_DOUT, ST_IAK: cnt_next = rply ? cnt_reg : cnt_reg + CNT_W'(1);
        default:                 cnt_next = '0;
      endcase
    end
  end

  assign cc_ra   = ra_reg;
  assign cc_berr = berr_reg;
  assign rd_data = rd_data_reg;
  assign dal_out = dal_out_reg;
  assign dal_oe  = dal_oe_reg;
  assign bsync_o = bsync_reg;
  assign bdin_o  = bdin_reg;
  assign bdout_o = bdout_reg;
  assign bwtbt_o = bwtbt_reg;
  assign biako_o = biako_reg;

endmodule

// File: tb/tb_qbus_cycle_seq.sv
// Directed bench for qbus_cycle_seq: read, byte write, timeout, IAK, priority, stuck RPLY, reset.
module tb_qbus_cycle_seq;

  localparam int T_ASET = 2;
  localparam int T_DSET = 2;
  localparam int TMO    = 1024;
  localparam int SYNC_N = 2;

  logic        clk = 1'b0;
  logic        pin_rst;
  logic        cc_syn, cc_di, cc_do, cc_wrby, cc_inrak;
  logic        cc_ra, cc_berr;
  logic [15:0] ad_in, rd_data, dal_in, dal_out;
  logic        dal_oe, bsync_o, bdin_o, bdout_o, bwtbt_o, biako_o;
  logic        brply_in;

  int n_cmp = 0;
  int n_err = 0;
  int berr_cnt = 0;

  qbus_cycle_seq #(
    .T_ASET (T_ASET),
    .T_DSET (T_DSET),
    .TMO    (TMO),
    .SYNC_N (SYNC_N)
  ) dut (
    .pin_clk  (clk),
    .pin_rst  (pin_rst),
    .cc_syn   (cc_syn),
    .cc_di    (cc_di),
    .cc_do    (cc_do),
    .cc_wrby  (cc_wrby),
    .cc_inrak (cc_inrak),
    .cc_ra    (cc_ra),
    .cc_berr  (cc_berr),
    .ad_in    (ad_in),
    .rd_data  (rd_data),
    .dal_in   (dal_in),
    .dal_out  (dal_out),
    .dal_oe   (dal_oe),
    .bsync_o  (bsync_o),
    .bdin_o   (bdin_o),
    .bdout_o  (bdout_o),
    .bwtbt_o  (bwtbt_o),
    .biako_o  (biako_o),
    .brply_in (brply_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cc_berr) berr_cnt <= berr_cnt + 1;

  // {bsync, bdin, bdout, bwtbt, biako, dal_oe, ra, berr}
  logic [7:0] strobes;
  assign strobes = {bsync_o, bdin_o, bdout_o, bwtbt_o, biako_o, dal_oe, cc_ra, cc_berr};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise cc_syn and confirm bsync arrives exactly T_ASET+1 clocks later.
  task automatic start_cycle(input logic [15:0] addr, input string tag);
    ad_in  = addr;
    cc_syn = 1'b1;
    step(1);
    check_eq({tag, "_dal_oe_addr"}, 32'(dal_oe), 32'd1);
    check_eq({tag, "_dal_out_addr"}, 32'(dal_out), 32'(addr));
    step(T_ASET);
    check_eq({tag, "_bsync_early"}, 32'(bsync_o), 32'd0);
    step(1);
    check_eq({tag, "_bsync_on"}, 32'(bsync_o), 32'd1);
    check_eq({tag, "_dal_oe_off"}, 32'(dal_oe), 32'd0);
  endtask

  initial begin
    pin_rst = 1'b1; cc_syn = 0; cc_di = 0; cc_do = 0; cc_wrby = 0; cc_inrak = 0;
    ad_in = '0; dal_in = '0; brply_in = 0;
    step(2);
    pin_rst = 1'b0;
    check_eq("reset_strobes", 32'(strobes), 32'd0);
    check_eq("reset_rd_data", 32'(rd_data), 32'd0);
    check_eq("reset_dal_out", 32'(dal_out), 32'd0);
    step(1);
    $display("reset: strobes=%b", strobes);

    // Read
    start_cycle(16'o177560, "rd");
    cc_di = 1'b1;
    step(1);
    check_eq("rd_bdin", 32'(bdin_o), 32'd1);
    check_eq("rd_bdout", 32'(bdout_o), 32'd0);
    step(5);
    dal_in = 16'h00A5; brply_in = 1'b1;
    step(1);
    check_eq("rd_ra_lat1", 32'(cc_ra), 32'd0);
    step(1);
    check_eq("rd_ra_lat2", 32'(cc_ra), 32'd0);
    step(1);
    check_eq("rd_ra", 32'(cc_ra), 32'd1);
    check_eq("rd_data", 32'(rd_data), 32'h00A5);
    cc_di = 1'b0;
    step(1);
    check_eq("rd_release", 32'({bdin_o, cc_ra, bsync_o}), 32'b001);
    brply_in = 1'b0;
    step(3);
    cc_syn = 1'b0;
    step(1);
    check_eq("rd_bsync_off", 32'(bsync_o), 32'd0);
    $display("read: addr=%o rd_data=%h", 16'o177560, rd_data);

    // Byte write
    start_cycle(16'o001000, "wr");
    cc_do = 1'b1; cc_wrby = 1'b1; ad_in = 16'h1234;
    step(1);
    check_eq("wr_dset", 32'({dal_oe, bwtbt_o, bdout_o}), 32'b110);
    check_eq("wr_dal_out", 32'(dal_out), 32'h1234);
    step(1);
    check_eq("wr_bdout_early", 32'(bdout_o), 32'd0);
    step(1);
    check_eq("wr_bdout_on", 32'(bdout_o), 32'd1);
    brply_in = 1'b1;
    step(3);
    check_eq("wr_ra", 32'({cc_ra, bdout_o}), 32'b11);
    cc_do = 1'b0; cc_wrby = 1'b0;
    step(1);
    check_eq("wr_release", 32'(strobes), 32'b1000_0000);
    brply_in = 1'b0;
    step(3);
    cc_syn = 1'b0;
    step(1);
    check_eq("wr_bsync_off", 32'(bsync_o), 32'd0);
    $display("write: dal_out=%h bwtbt seen", dal_out);

    // Timeout
    start_cycle(16'o160000, "tmo");
    cc_di = 1'b1;
    step(1);
    check_eq("tmo_bdin", 32'(bdin_o), 32'd1);
    step(TMO - 1);
    check_eq("tmo_berr_early", 32'(cc_berr), 32'd0);
    step(1);
    check_eq("tmo_berr", 32'(strobes), 32'b1000_0001);
    step(1);
    check_eq("tmo_berr_pulse", 32'(cc_berr), 32'd0);
    cc_di = 1'b0; cc_syn = 1'b0;
    step(1);
    check_eq("tmo_idle", 32'(strobes), 32'd0);
    $display("timeout: berr_cnt=%0d", berr_cnt);

    // Interrupt acknowledge
    cc_inrak = 1'b1; cc_di = 1'b1;
    step(1);
    check_eq("iak_strobes", 32'(strobes), 32'b0100_1000);
    dal_in = 16'o000060; brply_in = 1'b1;
    step(3);
    check_eq("iak_ra", 32'({cc_ra, bsync_o}), 32'b10);
    check_eq("iak_vector", 32'(rd_data), 32'o60);
    cc_di = 1'b0; cc_inrak = 1'b0;
    step(1);
    check_eq("iak_release", 32'(strobes), 32'd0);
    brply_in = 1'b0;
    step(4);
    check_eq("iak_idle", 32'(strobes), 32'd0);
    $display("iak: vector=%o", rd_data);

    // di and do together in ADDR
    start_cycle(16'o000200, "both");
    cc_di = 1'b1; cc_do = 1'b1;
    step(1);
    check_eq("both_read_path", 32'({bdin_o, bdout_o, dal_oe}), 32'b100);
    dal_in = 16'h5A5A; brply_in = 1'b1;
    step(3);
    check_eq("both_rd_data", 32'(rd_data), 32'h5A5A);
    cc_di = 1'b0; cc_do = 1'b0;
    step(1);
    brply_in = 1'b0;
    step(3);
    cc_syn = 1'b0;
    step(1);
    check_eq("both_bsync_off", 32'(bsync_o), 32'd0);
    $display("both: read path rd_data=%h", rd_data);

    // Stuck RPLY after release: no timeout, bsync held past cc_syn drop
    start_cycle(16'o000400, "stk");
    cc_di = 1'b1;
    step(1);
    dal_in = 16'hBEEF; brply_in = 1'b1;
    step(3);
    check_eq("stk_ra", 32'(cc_ra), 32'd1);
    cc_di = 1'b0;
    step(1);
    check_eq("stk_release", 32'({bdin_o, cc_ra}), 32'b00);
    step(TMO + 8);
    check_eq("stk_no_berr", 32'(berr_cnt), 32'd1);
    cc_syn = 1'b0;
    step(2);
    check_eq("stk_bsync_held", 32'(bsync_o), 32'd1);
    brply_in = 1'b0;
    step(3);
    check_eq("stk_addr_bsync", 32'(bsync_o), 32'd1);
    step(1);
    check_eq("stk_bsync_off", 32'(bsync_o), 32'd0);
    $display("stuck rply: berr_cnt=%0d", berr_cnt);

    // Reset during DOUT
    start_cycle(16'o002000, "rst");
    cc_do = 1'b1; ad_in = 16'hCAFE;
    step(3);
    check_eq("rst_bdout_on", 32'(bdout_o), 32'd1);
    pin_rst = 1'b1;
    step(1);
    check_eq("rst_strobes", 32'(strobes), 32'd0);
    check_eq("rst_dal_out", 32'(dal_out), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    pin_rst = 1'b0; cc_do = 1'b0; cc_syn = 1'b0;
    step(2);
    check_eq("rst_after", 32'(strobes), 32'd0);
    check_eq("rst_no_berr", 32'(berr_cnt), 32'd1);
    start_cycle(16'o003000, "post");
    cc_syn = 1'b0;
    step(1);
    check_eq("post_bsync_off", 32'(bsync_o), 32'd0);
    $display("reset in dout: strobes=%b", strobes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
